max3421_spi_responder: RTL and testbench

// SPI mode-0 responder (slave) modelling the MAX3421 register interface: the far end of our SPI master.

---
 rtl/max3421_spi_responder.sv | 194 +++++++++++++++++++
 tb/tb_max3421_spi_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max3421_spi_responder.sv
// -----------------------------------------------------------------------------
// max3421_spi_responder
// SPI mode-0 responder modelling the MAX3421 register interface. It decodes a
// command byte (addr = cmd[7:3], cmd[1] = 1 for write), then serves multi-byte
// register writes or reads on a 32x8 register file. The local port gives the
// system side direct access to the same registers.
//
// Optional feature: define MAX3421_SPI_RESP_AUTOINC_EN to step the register
// address by one (wrapping 31->0) after every data byte. Without it the
// address stays fixed for the whole transaction (FIFO-register behaviour).
//
// Ports
//   clk_in        system clock, at least 4x the sclk_in frequency
//   n_rst_in      asynchronous active-low reset
//   sclk_in       SPI clock from the master, idle low
//   n_ss_in       SPI select, active low
//   mosi_in       serial data in, MSB first
//   miso_out      serial data out, MSB first
//   miso_oe_out   tristate enable, high while selected
//   status_in     status byte shifted out during the command byte
//   loc_addr_in   local register address
//   loc_wr_in     local write strobe
//   loc_data_in   local write data
//   loc_data_out  regs[loc_addr_in], combinational
//   wr_valid_out  one-cycle pulse per completed SPI write byte
//   wr_addr_out   address of that write
//   wr_data_out   data of that write
// -----------------------------------------------------------------------------
module max3421_spi_responder #(
    parameter int NUM_REGS   = 32,
    parameter int SYNC_DEPTH = 2
) (
    input  logic       clk_in,
    input  logic       n_rst_in,
    input  logic       sclk_in,
    input  logic       n_ss_in,
    input  logic       mosi_in,
    output logic       miso_out,
    output logic       miso_oe_out,
    input  logic [7:0] status_in,
    input  logic [4:0] loc_addr_in,
    input  logic       loc_wr_in,
    input  logic [7:0] loc_data_in,
    output logic [7:0] loc_data_out,
    output logic       wr_valid_out,
    output logic [4:0] wr_addr_out,
    output logic [7:0] wr_data_out
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                state;
    logic [SYNC_DEPTH-1:0] sclk_sync;
    logic [SYNC_DEPTH-1:0] ss_sync;
    logic [SYNC_DEPTH-1:0] mosi_sync;
    logic                  sclk_s;
    logic                  ss_s;
    logic                  mosi_s;
    logic                  sclk_prev;
    logic                  ss_prev;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic [7:0]            regs [NUM_REGS];
    logic [7:0]            rx;
    logic [7:0]            rx_next;
    logic [7:0]            tx;
    logic [2:0]            bit_cnt;
    logic [4:0]            addr;
    logic [4:0]            addr_next;
    logic                  dir;
    logic                  byte_done;
    logic                  spi_we;

    // ---- input synchronisers and edge detection ----
    // Select resets to deselected so leaving reset never looks like a select.
    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_DEPTH-2:0], sclk_in};
            ss_sync   <= {ss_sync[SYNC_DEPTH-2:0], n_ss_in};
            mosi_sync <= {mosi_sync[SYNC_DEPTH-2:0], mosi_in};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_DEPTH-1];
    assign ss_s      = ss_sync[SYNC_DEPTH-1];
    assign mosi_s    = mosi_sync[SYNC_DEPTH-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign rx_next   = {rx[6:0], mosi_s};

    // A byte completes on the 8th rising edge of an active transaction.
    assign byte_done = sclk_rise && !ss_s && (state != IDLE) && (bit_cnt == 3'd7);
    assign spi_we    = byte_done && (state == DATA) && dir;

`ifdef MAX3421_SPI_RESP_AUTOINC_EN
    assign addr_next = addr + 5'd1;
`else
    assign addr_next = addr;
`endif

    // ---- transaction FSM ----
    // tx holds the bits still to be driven; miso_out is the bit on the wire.
    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            state        <= IDLE;
            bit_cnt      <= 3'd0;
            rx           <= 8'h00;
            tx           <= 8'h00;
            addr         <= 5'd0;
            dir          <= 1'b0;
            miso_out     <= 1'b0;
            miso_oe_out  <= 1'b0;
            wr_valid_out <= 1'b0;
            wr_addr_out  <= 5'd0;
            wr_data_out  <= 8'h00;
        end else begin
            wr_valid_out <= 1'b0;
            if (ss_s) begin
                // Deselected: abandon any partial byte.
                state       <= IDLE;
                bit_cnt     <= 3'd0;
                miso_oe_out <= 1'b0;
                miso_out    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ss_prev) begin
                            state       <= CMD;
                            bit_cnt     <= 3'd0;
                            tx          <= {status_in[6:0], 1'b0};
                            miso_out    <= status_in[7];
                            miso_oe_out <= 1'b1;
                        end
                    end
                    default: begin
                        if (sclk_rise) begin
                            rx      <= rx_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == CMD) begin
                                    addr  <= rx_next[7:3];
                                    dir   <= rx_next[1];
                                    state <= DATA;
                                    tx    <= regs[rx_next[7:3]];
                                end else begin
                                    if (dir) begin
                                        wr_valid_out <= 1'b1;
                                        wr_addr_out  <= addr;
                                        wr_data_out  <= rx_next;
                                    end
                                    // Reload reads the pre-write array: a
                                    // same-cycle local write is not seen.
                                    addr <= addr_next;
                                    tx   <= regs[addr_next];
                                end
                            end
                        end else if (sclk_fall) begin
                            miso_out <= tx[7];
                            tx       <= {tx[6:0], 1'b0};
                        end
                    end
                endcase
            end
        end
    end

    // ---- register file ----
    // Local write is suppressed when the SPI side writes the same address.
    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            if (loc_wr_in && !(spi_we && (loc_addr_in == addr))) begin
                regs[loc_addr_in] <= loc_data_in;
            end
            if (spi_we) begin
                regs[addr] <= rx_next;
            end
        end
    end

    assign loc_data_out = regs[loc_addr_in];

endmodule

// File: tb/tb_max3421_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_max3421_spi_responder
// Directed bench for max3421_spi_responder: acts as a mode-0 SPI master with a
// slow sclk, checks MISO bytes, write pulses and register contents through the
// local port. Expectations follow MAX3421_SPI_RESP_AUTOINC_EN when defined.
// -----------------------------------------------------------------------------
module tb_max3421_spi_responder;

    localparam int HALF = 6;  // clk cycles per sclk half period

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       sclk = 1'b0;
    logic       n_ss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso_out;
    logic       miso_oe_out;
    logic [7:0] status = 8'h00;
    logic [4:0] loc_addr = 5'd0;
    logic       loc_wr = 1'b0;
    logic [7:0] loc_data = 8'h00;
    logic [7:0] loc_data_out;
    logic       wr_valid_out;
    logic [4:0] wr_addr_out;
    logic [7:0] wr_data_out;

    int nvec = 0;
    int nerr = 0;

    int         wv_total = 0;
    logic [4:0] wv_addr [64];
    logic [7:0] wv_data [64];

    max3421_spi_responder dut (
        .clk_in       (clk),
        .n_rst_in     (n_rst),
        .sclk_in      (sclk),
        .n_ss_in      (n_ss),
        .mosi_in      (mosi),
        .miso_out     (miso_out),
        .miso_oe_out  (miso_oe_out),
        .status_in    (status),
        .loc_addr_in  (loc_addr),
        .loc_wr_in    (loc_wr),
        .loc_data_in  (loc_data),
        .loc_data_out (loc_data_out),
        .wr_valid_out (wr_valid_out),
        .wr_addr_out  (wr_addr_out),
        .wr_data_out  (wr_data_out)
    );

    always #5 clk = ~clk;

    // Record every write pulse, sampled on the inactive edge.
    always @(negedge clk) begin
        if (wr_valid_out) begin
            wv_addr[wv_total[5:0]] = wr_addr_out;
            wv_data[wv_total[5:0]] = wr_data_out;
            wv_total = wv_total + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic ss_begin();
        @(negedge clk);
        n_ss = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic ss_end();
        repeat (HALF) @(negedge clk);
        n_ss = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Shift nbits of d (MSB first); r gets MISO sampled just before each
    // rising edge. With coll set, loc_wr is pulsed in the exact cycle the
    // DUT acts on the last rising edge (SYNC_DEPTH+1 cycles after the pin).
    task automatic spi_bits(input logic [7:0] d, input int nbits, input bit coll,
                            output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = d[i];
            repeat (HALF) @(negedge clk);
            r[i] = miso_out;
            sclk = 1'b1;
            if (coll && i == 0) begin
                repeat (2) @(negedge clk);
                loc_wr = 1'b1;
                @(negedge clk);
                loc_wr = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        loc_addr = a;
        loc_data = d;
        loc_wr   = 1'b1;
        @(negedge clk);
        loc_wr   = 1'b0;
    endtask

    task automatic loc_read(input logic [4:0] a, output logic [7:0] v);
        @(negedge clk);
        loc_addr = a;
        #1;
        v = loc_data_out;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        nvec++; if (miso_out !== 1'b0) begin $display("FAIL reset_miso got %b want 0", miso_out); nerr++; end
        nvec++; if (miso_oe_out !== 1'b0) begin $display("FAIL reset_oe got %b want 0", miso_oe_out); nerr++; end
        nvec++; if (wr_valid_out !== 1'b0) begin $display("FAIL reset_wr_valid got %b want 0", wr_valid_out); nerr++; end
        nvec++; if (wr_addr_out !== 5'd0 || wr_data_out !== 8'h00) begin
            $display("FAIL reset_wr_bus got %h/%h want 00/00", wr_addr_out, wr_data_out); nerr++; end
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        loc_read(5'd18, v);
        nvec++; if (v !== 8'h00) begin $display("FAIL reset_reg18 got %h want 00", v); nerr++; end
    endtask

    task automatic test_status_read();
        logic [7:0] r;
        status = 8'h5A;
        ss_begin();
        nvec++; if (miso_oe_out !== 1'b1) begin $display("FAIL status_oe_sel got %b want 1", miso_oe_out); nerr++; end
        spi_bits(8'h90, 8, 1'b0, r);
        nvec++; if (r !== 8'h5A) begin $display("FAIL status_byte got %h want 5a", r); nerr++; end
        spi_bits(8'h00, 8, 1'b0, r);
        nvec++; if (r !== 8'h00) begin $display("FAIL status_reg18 got %h want 00", r); nerr++; end
        ss_end();
        nvec++; if (miso_oe_out !== 1'b0) begin $display("FAIL status_oe_desel got %b want 0", miso_oe_out); nerr++; end
        nvec++; if (miso_out !== 1'b0) begin $display("FAIL status_miso_desel got %b want 0", miso_out); nerr++; end
    endtask

    task automatic test_write();
        logic [7:0] r, v17, v18;
        int base, b1;
        base = wv_total;
        b1 = base + 1;
        ss_begin();
        spi_bits(8'h8A, 8, 1'b0, r);
        spi_bits(8'h14, 8, 1'b0, r);
        spi_bits(8'hFF, 8, 1'b0, r);
        ss_end();
        nvec++; if (wv_total - base !== 2) begin $display("FAIL write_pulses got %0d want 2", wv_total - base); nerr++; end
        nvec++; if (wv_addr[base[5:0]] !== 5'd17 || wv_data[base[5:0]] !== 8'h14) begin
            $display("FAIL write_pulse0 got %0d/%h want 17/14", wv_addr[base[5:0]], wv_data[base[5:0]]); nerr++; end
`ifdef MAX3421_SPI_RESP_AUTOINC_EN
        nvec++; if (wv_addr[b1[5:0]] !== 5'd18 || wv_data[b1[5:0]] !== 8'hFF) begin
            $display("FAIL write_pulse1 got %0d/%h want 18/ff", wv_addr[b1[5:0]], wv_data[b1[5:0]]); nerr++; end
        loc_read(5'd17, v17);
        loc_read(5'd18, v18);
        nvec++; if (v17 !== 8'h14) begin $display("FAIL write_reg17 got %h want 14", v17); nerr++; end
        nvec++; if (v18 !== 8'hFF) begin $display("FAIL write_reg18 got %h want ff", v18); nerr++; end
`else
        nvec++; if (wv_addr[b1[5:0]] !== 5'd17 || wv_data[b1[5:0]] !== 8'hFF) begin
            $display("FAIL write_pulse1 got %0d/%h want 17/ff", wv_addr[b1[5:0]], wv_data[b1[5:0]]); nerr++; end
        loc_read(5'd17, v17);
        loc_read(5'd18, v18);
        nvec++; if (v17 !== 8'hFF) begin $display("FAIL write_reg17 got %h want ff", v17); nerr++; end
        nvec++; if (v18 !== 8'h00) begin $display("FAIL write_reg18 got %h want 00", v18); nerr++; end
`endif
    endtask

    task automatic test_read();
        logic [7:0] r, r1, r2;
        loc_write(5'd18, 8'hA5);
        loc_write(5'd19, 8'h3C);
        ss_begin();
        spi_bits(8'h90, 8, 1'b0, r);
        spi_bits(8'h00, 8, 1'b0, r1);
        spi_bits(8'h00, 8, 1'b0, r2);
        ss_end();
        nvec++; if (r1 !== 8'hA5) begin $display("FAIL read_byte0 got %h want a5", r1); nerr++; end
`ifdef MAX3421_SPI_RESP_AUTOINC_EN
        nvec++; if (r2 !== 8'h3C) begin $display("FAIL read_byte1 got %h want 3c", r2); nerr++; end
`else
        nvec++; if (r2 !== 8'hA5) begin $display("FAIL read_byte1 got %h want a5", r2); nerr++; end
`endif
    endtask

    task automatic test_abort();
        logic [7:0] r, v, exp17;
        int base;
`ifdef MAX3421_SPI_RESP_AUTOINC_EN
        exp17 = 8'h14;
`else
        exp17 = 8'hFF;
`endif
        base = wv_total;
        ss_begin();
        spi_bits(8'h8A, 8, 1'b0, r);
        spi_bits(8'h00, 5, 1'b0, r);
        ss_end();
        nvec++; if (wv_total !== base) begin $display("FAIL abort_pulses got %0d want 0", wv_total - base); nerr++; end
        loc_read(5'd17, v);
        nvec++; if (v !== exp17) begin $display("FAIL abort_reg17 got %h want %h", v, exp17); nerr++; end
        nvec++; if (miso_oe_out !== 1'b0) begin $display("FAIL abort_oe got %b want 0", miso_oe_out); nerr++; end
        // A fresh transaction must start on a byte boundary again.
        status = 8'hC3;
        ss_begin();
        spi_bits(8'h90, 8, 1'b0, r);
        ss_end();
        nvec++; if (r !== 8'hC3) begin $display("FAIL abort_next_status got %h want c3", r); nerr++; end
    endtask

    task automatic test_wrap();
        logic [7:0] r, v31, v0;
        int base;
        base = wv_total;
        ss_begin();
        spi_bits(8'hFA, 8, 1'b0, r);
        spi_bits(8'h11, 8, 1'b0, r);
        spi_bits(8'h22, 8, 1'b0, r);
        ss_end();
        loc_read(5'd31, v31);
        loc_read(5'd0, v0);
        nvec++; if (wv_total - base !== 2) begin $display("FAIL wrap_pulses got %0d want 2", wv_total - base); nerr++; end
`ifdef MAX3421_SPI_RESP_AUTOINC_EN
        nvec++; if (v31 !== 8'h11) begin $display("FAIL wrap_reg31 got %h want 11", v31); nerr++; end
        nvec++; if (v0 !== 8'h22) begin $display("FAIL wrap_reg0 got %h want 22", v0); nerr++; end
`else
        nvec++; if (v31 !== 8'h22) begin $display("FAIL wrap_reg31 got %h want 22", v31); nerr++; end
        nvec++; if (v0 !== 8'h00) begin $display("FAIL wrap_reg0 got %h want 00", v0); nerr++; end
`endif
    endtask

    task automatic test_collision();
        logic [7:0] r, v9, v5;
        ss_begin();
        spi_bits(8'h4A, 8, 1'b0, r);
        loc_addr = 5'd9;
        loc_data = 8'hEE;
        spi_bits(8'h55, 8, 1'b1, r);
        ss_end();
        loc_read(5'd9, v9);
        nvec++; if (v9 !== 8'h55) begin $display("FAIL coll_same_reg9 got %h want 55", v9); nerr++; end
        ss_begin();
        spi_bits(8'h4A, 8, 1'b0, r);
        loc_addr = 5'd5;
        loc_data = 8'h66;
        spi_bits(8'hAA, 8, 1'b1, r);
        ss_end();
        loc_read(5'd9, v9);
        loc_read(5'd5, v5);
        nvec++; if (v9 !== 8'hAA) begin $display("FAIL coll_diff_reg9 got %h want aa", v9); nerr++; end
        nvec++; if (v5 !== 8'h66) begin $display("FAIL coll_diff_reg5 got %h want 66", v5); nerr++; end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r, v;
        int nonzero;
        ss_begin();
        spi_bits(8'h8A, 8, 1'b0, r);
        spi_bits(8'hF0, 4, 1'b0, r);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        nvec++; if (miso_oe_out !== 1'b0 || miso_out !== 1'b0) begin
            $display("FAIL rstmid_outputs got oe=%b miso=%b want 0/0", miso_oe_out, miso_out); nerr++; end
        n_ss = 1'b1;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
        loc_read(5'd31, v);
        nvec++; if (v !== 8'h00) begin $display("FAIL rstmid_reg31 got %h want 00", v); nerr++; end
        ss_begin();
        spi_bits(8'h1A, 8, 1'b0, r);
        spi_bits(8'h77, 8, 1'b0, r);
        ss_end();
        loc_read(5'd3, v);
        nvec++; if (v !== 8'h77) begin $display("FAIL rstmid_reg3 got %h want 77", v); nerr++; end
        nonzero = 0;
        for (int a = 0; a < 32; a++) begin
            if (a != 3) begin
                loc_read(a[4:0], v);
                if (v !== 8'h00) nonzero++;
            end
        end
        nvec++; if (nonzero !== 0) begin $display("FAIL rstmid_others got %0d nonzero want 0", nonzero); nerr++; end
    endtask

    initial begin
        test_reset();
        test_status_read();
        test_write();
        test_read();
        test_abort();
        test_wrap();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
